pwm_peripheral: RTL

Output stage fed by the SPI register block: consumes the five 8-bit configuration registers (output enable low/high, PWM enable low/high, duty cycle) and drives 16 output pins. Each pin is one of three things: forced low, forced high, or a shared PWM waveform whose period and duty come from a prescaled 8-bit counter. Duty updates are glitch-free at period boundaries unless configured otherwise.

---
 rtl/pwm_pkg.sv | 11 +
 rtl/pwm_tick_gen.sv | 28 ++
 rtl/pwm_peripheral.sv | 70 +++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// Shared constants and types for the PWM output stage.
// Counter width, wrap value, full-duty code and the 16-pin vector type.
package pwm_pkg;

  localparam int PWM_CNT_W = 8;
  localparam logic [PWM_CNT_W-1:0] PWM_MAX = 8'd254;
  localparam logic [PWM_CNT_W-1:0] DUTY_FULL = 8'hFF;

  typedef logic [15:0] pin_vec_t;

endpackage

// File: rtl/pwm_tick_gen.sv
// Prescaler: tick is high for one clock every CLK_DIV clocks.
// Ports: clk, rst_n (async low), tick. Parameter CLK_DIV >= 2.
module pwm_tick_gen #(
  parameter int CLK_DIV = 3000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;

  assign tick = (div_cnt == DIV_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pwm_peripheral.sv
// 16-pin output stage: each pin forced low, forced high or shared PWM.
// Ports: clk, rst_n, en_out, en_pwm, duty -> out, period_start. Macro: PWM_SHADOW_EN.
module pwm_peripheral
  import pwm_pkg::*;
#(
  parameter int CLK_DIV = 3000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  pin_vec_t   en_out,
  input  pin_vec_t   en_pwm,
  input  logic [7:0] duty,
  output pin_vec_t   out,
  output logic       period_start
);

  logic                 tick;
  logic                 wrap;
  logic                 pwm_lvl;
  logic [PWM_CNT_W-1:0] pwm_cnt;
  logic [PWM_CNT_W-1:0] duty_eff;
  pin_vec_t             out_nxt;

  pwm_tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );

  assign wrap = tick && (pwm_cnt == PWM_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt <= '0;
    end else if (tick) begin
      pwm_cnt <= wrap ? '0 : pwm_cnt + 1'b1;
    end
  end

`ifdef PWM_SHADOW_EN
  // Duty only changes at the period boundary, so no runt pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_eff <= '0;
    end else if (wrap) begin
      duty_eff <= duty;
    end
  end
`else
  assign duty_eff = duty;
`endif

  assign pwm_lvl = (duty_eff == DUTY_FULL) || (pwm_cnt < duty_eff);

  // Enabled pins drive 1 unless PWM-selected, then follow the waveform.
  assign out_nxt = en_out & (~en_pwm | {16{pwm_lvl}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out          <= '0;
      period_start <= 1'b0;
    end else begin
      out          <= out_nxt;
      period_start <= wrap;
    end
  end

endmodule
